// File: rtl/ssd_pkg.sv
// Shared types, constants and helpers for the keypad/PmodSSD entry driver.
package ssd_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } entry_state_t;

  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  // Refresh-divider counter width; a quotient of 2 still needs one bit.
  function automatic int div_width(input int div);
    return (div > 2) ? $clog2(div) : 1;
  endfunction

  // Segment order {a,b,c,d,e,f,g}, active high.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'b1111110;
      4'h1: s = 7'b0110000;
      4'h2: s = 7'b1101101;
      4'h3: s = 7'b1111001;
      4'h4: s = 7'b0110011;
      4'h5: s = 7'b1011011;
      4'h6: s = 7'b1011111;
      4'h7: s = 7'b1110000;
      4'h8: s = 7'b1111111;
      4'h9: s = 7'b1111011;
      4'hA: s = 7'b1110111;
      4'hB: s = 7'b0011111;
      4'hC: s = 7'b1001110;
      4'hD: s = 7'b0111101;
      4'hE: s = 7'b1001111;
      default: s = 7'b1000111;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/ssd_entry_driver_disp_ctrl.sv
// Segment decoder with blanking; the segment register loads only on slot
// boundaries so the bus never changes apart from chip_sel.
module disp_ctrl
  import ssd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] digit,
  input  logic       valid,
  output logic [6:0] seg
);

  logic [6:0] seg_q, seg_d;

  always_comb begin
    seg_d = seg_q;
    if (load) seg_d = valid ? hex_to_seg(digit) : SEG_BLANK;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) seg_q <= SEG_BLANK;
    else     seg_q <= seg_d;
  end

  assign seg = seg_q;

endmodule

// File: rtl/ssd_entry_driver.sv
// Two-digit keypad entry buffer with a time-multiplexed 7-segment driver.
// Handshake: key_valid and clr are single-cycle strobes with no back-pressure.
module ssd_entry_driver
  import ssd_pkg::*;
#(
  parameter int clk_freq   = 125_000_000,
  parameter int refresh_hz = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic       mode,
  input  logic       clr,
  output logic [6:0] seg,
  output logic       chip_sel,
  output logic [3:0] digit_l,
  output logic [3:0] digit_r,
  output logic       l_valid,
  output logic       r_valid,
  output logic [1:0] entry_state
);

  localparam int DIV = clk_freq / refresh_hz;
  localparam int CW  = div_width(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          chip_sel_q, chip_sel_d;
  logic [3:0]    digit_l_q, digit_l_d, digit_r_q, digit_r_d;
  logic          l_valid_q, l_valid_d, r_valid_q, r_valid_d;
  logic          mode_q;
  entry_state_t  state_q, state_d;

  logic       wrap;
  logic       clear;
  logic [3:0] nxt_digit;
  logic       nxt_valid;

  always_comb begin
    wrap       = (cnt_q == LAST);
    cnt_d      = wrap ? '0 : cnt_q + 1'b1;
    chip_sel_d = wrap ? ~chip_sel_q : chip_sel_q;
    // The segment register is fed with the slot about to be selected.
    nxt_digit  = chip_sel_q ? digit_r_q : digit_l_q;
    nxt_valid  = chip_sel_q ? r_valid_q : l_valid_q;
  end

  always_comb begin
    clear     = clr | (mode != mode_q);
    digit_l_d = digit_l_q;
    digit_r_d = digit_r_q;
    l_valid_d = l_valid_q;
    r_valid_d = r_valid_q;
    state_d   = state_q;
    if (clear) begin
      l_valid_d = 1'b0;
      r_valid_d = 1'b0;
      state_d   = EMPTY;
    end else if (!mode) begin
      l_valid_d = 1'b0;
      state_d   = EMPTY;
      if (key_valid) begin
        digit_r_d = key_code;
        r_valid_d = 1'b1;
      end
    end else if (key_valid) begin
      case (state_q)
        EMPTY: begin
          digit_l_d = key_code;
          l_valid_d = 1'b1;
          state_d   = ONE;
        end
        ONE: begin
          digit_r_d = key_code;
          r_valid_d = 1'b1;
          state_d   = TWO;
        end
        default: begin
          // A third key starts a fresh entry; the old right digit stays hidden.
          digit_l_d = key_code;
          l_valid_d = 1'b1;
          r_valid_d = 1'b0;
          state_d   = ONE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      chip_sel_q <= 1'b0;
      digit_l_q  <= '0;
      digit_r_q  <= '0;
      l_valid_q  <= 1'b0;
      r_valid_q  <= 1'b0;
      mode_q     <= 1'b0;
      state_q    <= EMPTY;
    end else begin
      cnt_q      <= cnt_d;
      chip_sel_q <= chip_sel_d;
      digit_l_q  <= digit_l_d;
      digit_r_q  <= digit_r_d;
      l_valid_q  <= l_valid_d;
      r_valid_q  <= r_valid_d;
      mode_q     <= mode;
      state_q    <= state_d;
    end
  end

  disp_ctrl u_disp_ctrl (
    .clk   (clk),
    .rst   (rst),
    .load  (wrap),
    .digit (nxt_digit),
    .valid (nxt_valid),
    .seg   (seg)
  );

  assign chip_sel    = chip_sel_q;
  assign digit_l     = digit_l_q;
  assign digit_r     = digit_r_q;
  assign l_valid     = l_valid_q;
  assign r_valid     = r_valid_q;
  assign entry_state = state_q;

endmodule

// File: tb/tb_ssd_entry_driver.sv
// Directed bench for ssd_entry_driver with a 4-cycle refresh slot.
module tb_ssd_entry_driver;

  localparam int W = 12;

  typedef struct {
    logic       kv;
    logic [3:0] kc;
    logic       md;
    logic       cl;
    logic [3:0] dl;
    logic [3:0] dr;
    logic       lv;
    logic       rv;
    logic [1:0] st;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_valid = 1'b0;
  logic [3:0] key_code = 4'h0;
  logic       mode = 1'b0;
  logic       clr = 1'b0;
  logic [6:0] seg;
  logic       chip_sel;
  logic [3:0] digit_l, digit_r;
  logic       l_valid, r_valid;
  logic [1:0] entry_state;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  vec_t tbl[$];

  // display reference state and the entry values it reads
  int         m_cnt;
  logic       m_cs;
  logic [6:0] m_seg;
  logic [3:0] c_dl, c_dr;
  logic       c_lv, c_rv;

  ssd_entry_driver #(.clk_freq(1000), .refresh_hz(250)) dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
    .mode(mode), .clr(clr), .seg(seg), .chip_sel(chip_sel),
    .digit_l(digit_l), .digit_r(digit_r), .l_valid(l_valid),
    .r_valid(r_valid), .entry_state(entry_state)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] seg_of(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'b1111110; 4'h1: s = 7'b0110000; 4'h2: s = 7'b1101101;
      4'h3: s = 7'b1111001; 4'h4: s = 7'b0110011; 4'h5: s = 7'b1011011;
      4'h6: s = 7'b1011111; 4'h7: s = 7'b1110000; 4'h8: s = 7'b1111111;
      4'h9: s = 7'b1111011; 4'hA: s = 7'b1110111; 4'hB: s = 7'b0011111;
      4'hC: s = 7'b1001110; 4'hD: s = 7'b0111101; 4'hE: s = 7'b1001111;
      default: s = 7'b1000111;
    endcase
    return s;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic add(input logic kv, input logic [3:0] kc, input logic md, input logic cl,
                     input logic [3:0] dl, input logic [3:0] dr, input logic lv,
                     input logic rv, input logic [1:0] st);
    vec_t v;
    v.kv = kv; v.kc = kc; v.md = md; v.cl = cl;
    v.dl = dl; v.dr = dr; v.lv = lv; v.rv = rv; v.st = st;
    tbl.push_back(v);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    key_valid = 1'b0;
    clr = 1'b0;
    mode = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic press(input logic [3:0] c);
    key_code = c;
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  // Wait (bounded) for chip_sel to switch to val; checked at negedge.
  task automatic wait_slot(input logic val, input string name);
    logic prev;
    bit   hit;
    prev = chip_sel;
    hit = 1'b0;
    for (int k = 0; k < 12 && !hit; k++) begin
      @(negedge clk);
      if (chip_sel == val && prev != val) hit = 1'b1;
      prev = chip_sel;
    end
    if (!hit) begin
      checks++;
      errors++;
      $display("FAIL %s timeout actual=%b expected=%b", name, chip_sel, val);
    end
  endtask

  task automatic check_divider(input string name, input bit with_seg);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      chk(name, 16'(chip_sel), 16'((k / 4) % 2));
      if (with_seg) chk({name, "_seg"}, 16'(seg), 16'h0);
    end
  endtask

  initial begin
    // Section A: refresh divider with no keys
    do_reset();
    chk("reset_seg", 16'(seg), 16'h0);
    chk("reset_cs", 16'(chip_sel), 16'h0);
    chk("reset_entry", {4'h0, digit_l, digit_r, l_valid, r_valid, entry_state}, 16'h0);
    check_divider("divider", 1'b1);

    // Section B: table-driven entry vectors with a per-edge display model
    add(0, 4'h0, 1, 0, 4'h0, 4'h0, 0, 0, 2'd0);
    add(1, 4'h3, 1, 0, 4'h3, 4'h0, 1, 0, 2'd1);
    add(1, 4'h7, 1, 0, 4'h3, 4'h7, 1, 1, 2'd2);
    for (int i = 0; i < 6; i++) add(0, 4'h0, 1, 0, 4'h3, 4'h7, 1, 1, 2'd2);
    add(1, 4'hA, 1, 0, 4'hA, 4'h7, 1, 0, 2'd1);
    for (int i = 0; i < 3; i++) add(0, 4'h0, 1, 0, 4'hA, 4'h7, 1, 0, 2'd1);
    add(1, 4'h5, 1, 1, 4'hA, 4'h7, 0, 0, 2'd0);
    add(1, 4'h4, 1, 0, 4'h4, 4'h7, 1, 0, 2'd1);
    add(1, 4'h9, 0, 0, 4'h4, 4'h7, 0, 0, 2'd0);
    add(1, 4'h1, 0, 0, 4'h4, 4'h1, 0, 1, 2'd0);
    add(1, 4'h2, 0, 0, 4'h4, 4'h2, 0, 1, 2'd0);
    for (int i = 0; i < 5; i++) add(0, 4'h0, 0, 0, 4'h4, 4'h2, 0, 1, 2'd0);
    add(0, 4'h0, 1, 0, 4'h4, 4'h2, 0, 0, 2'd0);
    add(1, 4'hE, 1, 0, 4'hE, 4'h2, 1, 0, 2'd1);
    add(1, 4'hF, 1, 0, 4'hE, 4'hF, 1, 1, 2'd2);
    add(1, 4'h0, 1, 0, 4'h0, 4'hF, 1, 0, 2'd1);
    add(0, 4'h0, 0, 0, 4'h0, 4'hF, 0, 0, 2'd0);
    add(1, 4'h3, 0, 1, 4'h0, 4'hF, 0, 0, 2'd0);
    for (int i = 0; i < 3; i++) add(0, 4'h0, 0, 0, 4'h0, 4'hF, 0, 0, 2'd0);

    do_reset();
    m_cnt = 0; m_cs = 1'b0; m_seg = 7'h0;
    c_dl = 4'h0; c_dr = 4'h0; c_lv = 1'b0; c_rv = 1'b0;
    for (int i = 0; i < tbl.size(); i++) begin
      key_valid = tbl[i].kv;
      key_code  = tbl[i].kc;
      mode      = tbl[i].md;
      clr       = tbl[i].cl;
      exp_q.push_back({tbl[i].dl, tbl[i].dr, tbl[i].lv, tbl[i].rv, tbl[i].st});
      @(posedge clk);
      if (m_cnt == 3) begin
        m_cnt = 0;
        m_seg = m_cs ? (c_rv ? seg_of(c_dr) : 7'h0) : (c_lv ? seg_of(c_dl) : 7'h0);
        m_cs  = ~m_cs;
      end else begin
        m_cnt++;
      end
      c_dl = tbl[i].dl; c_dr = tbl[i].dr; c_lv = tbl[i].lv; c_rv = tbl[i].rv;
      @(negedge clk);
      key_valid = 1'b0;
      clr = 1'b0;
      chk($sformatf("vec%0d_entry", i),
          16'({digit_l, digit_r, l_valid, r_valid, entry_state}), 16'(exp_q.pop_front()));
      chk($sformatf("vec%0d_cs", i), 16'(chip_sel), 16'(m_cs));
      chk($sformatf("vec%0d_seg", i), 16'(seg), 16'(m_seg));
    end

    // Section C: two-digit display values and restart blanking
    do_reset();
    mode = 1'b1;
    @(negedge clk);
    press(4'h3);
    press(4'h7);
    wait_slot(1'b0, "slot_r0");
    wait_slot(1'b1, "slot_l1");
    chk("two_left_seg", 16'(seg), 16'(7'b1111001));
    wait_slot(1'b0, "slot_r1");
    chk("two_right_seg", 16'(seg), 16'(7'b1110000));
    press(4'hA);
    chk("restart_state", 16'({digit_l, r_valid, entry_state}), 16'({4'hA, 1'b0, 2'd1}));
    wait_slot(1'b1, "slot_l2");
    wait_slot(1'b0, "slot_r2");
    chk("restart_right_blank", 16'(seg), 16'h0);
    wait_slot(1'b1, "slot_l3");
    chk("restart_left_seg", 16'(seg), 16'(7'b1110111));

    // Section D: asynchronous reset between edges
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("async_seg", 16'(seg), 16'h0);
    chk("async_cs", 16'(chip_sel), 16'h0);
    chk("async_entry", {4'h0, digit_l, digit_r, l_valid, r_valid, entry_state}, 16'h0);
    mode = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check_divider("post_reset_div", 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
